// File: rtl/jtag_debug_pkg.sv
// Shared constants for the JTAG debug command path: default register widths
// and the instruction-register codes decoded into take_action.
package jtag_debug_pkg;

   localparam int DR_WIDTH_DEF = 38;
   localparam int IR_WIDTH_DEF = 2;

   typedef enum logic [IR_WIDTH_DEF-1:0] {
      IR_OCIMEM    = 2'd0,
      IR_TRACEMEM  = 2'd1,
      IR_BREAK     = 2'd2,
      IR_TRACECTRL = 2'd3
   } ir_code_e;

endpackage

// File: rtl/jtag_debug_sync_edge.sv
// Multi-flop synchronizer for a TCK-domain level, plus a one-cycle pulse on its
// synchronized rising edge.
module jtag_debug_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   edge_q;
   logic                   arm_q;

   // vld_q marks when sync_q's output reflects a post-reset sample; arm_q only
   // sets once that genuine level is low, so a level held across reset never pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         vld_q  <= '0;
         edge_q <= 1'b0;
         arm_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         edge_q <= sync_q[SYNC_STAGES-1];
         arm_q  <= arm_q | (vld_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
      end
   end

   assign pulse_o = sync_q[SYNC_STAGES-1] & ~edge_q & arm_q;

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// Moves JTAG update-DR/update-IR events into the clk domain and queues
// {ir, dr} commands in a show-ahead FIFO. Define JTAG_DEBUG_OVF_COUNT_EN for a dropped-command counter.
module jtag_debug_cmd_sync
   import jtag_debug_pkg::*;
#(
   parameter int DR_WIDTH    = DR_WIDTH_DEF,
   parameter int IR_WIDTH    = IR_WIDTH_DEF,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [DR_WIDTH-1:0]        sr,
   input  logic [IR_WIDTH-1:0]        ir_in,
   input  logic                       vs_udr,
   input  logic                       vs_uir,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic [IR_WIDTH-1:0]        cmd_ir,
   output logic [DR_WIDTH-1:0]        jdo,
   output logic [2**IR_WIDTH-1:0]     take_action,
   output logic                       ir_update,
   output logic [IR_WIDTH-1:0]        ir_code,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   input  logic                       ovf_clr,
   output logic [7:0]                 ovf_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic                udr_push;
   logic                uir_pulse;
   logic [PW-1:0]       wptr_q, wptr_d;
   logic [PW-1:0]       rptr_q, rptr_d;
   logic                ovf_q, ovf_d;
   logic                ir_upd_q, ir_upd_d;
   logic [IR_WIDTH-1:0] ir_code_q, ir_code_d;
   logic [IR_WIDTH-1:0] mem_ir [DEPTH];
   logic [DR_WIDTH-1:0] mem_dr [DEPTH];
   logic                full, empty, pop, push_ok, drop;

   jtag_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (vs_udr),
      .pulse_o (udr_push)
   );

   jtag_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (vs_uir),
      .pulse_o (uir_pulse)
   );

   assign empty   = (wptr_q == rptr_q);
   assign full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
   assign pop     = ~empty & cmd_ready;
   assign push_ok = udr_push & (~full | pop);
   assign drop    = udr_push & full & ~pop;

   always_comb begin
      wptr_d    = wptr_q + PW'(push_ok);
      rptr_d    = rptr_q + PW'(pop);
      ovf_d     = drop | (ovf_q & ~ovf_clr);
      ir_upd_d  = uir_pulse;
      ir_code_d = uir_pulse ? ir_in : ir_code_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         ovf_q     <= 1'b0;
         ir_upd_q  <= 1'b0;
         ir_code_q <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         ovf_q     <= ovf_d;
         ir_upd_q  <= ir_upd_d;
         ir_code_q <= ir_code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_ir[wptr_q[AW-1:0]] <= ir_in;
         mem_dr[wptr_q[AW-1:0]] <= sr;
      end
   end

`ifdef JTAG_DEBUG_OVF_COUNT_EN
   logic [7:0] cnt_q, cnt_d;

   // A drop coinciding with a clear restarts the count at one.
   always_comb begin
      cnt_d = cnt_q;
      if (drop)
         cnt_d = ovf_clr ? 8'd1 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
      else if (ovf_clr)
         cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign ovf_count = cnt_q;
`else
   assign ovf_count = '0;
`endif

   always_comb begin
      take_action = '0;
      for (int unsigned i = 0; i < 2**IR_WIDTH; i++)
         take_action[i] = cmd_valid && (cmd_ir == IR_WIDTH'(i));
   end

   assign cmd_valid  = ~empty;
   assign cmd_ir     = mem_ir[rptr_q[AW-1:0]];
   assign jdo        = mem_dr[rptr_q[AW-1:0]];
   assign fifo_level = wptr_q - rptr_q;
   assign overflow   = ovf_q;
   assign ir_update  = ir_upd_q;
   assign ir_code    = ir_code_q;

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Self-checking bench for jtag_debug_cmd_sync: vector table plus a command
// scoreboard queue, with hand-written sequences for latency, overflow and reset.
module tb_jtag_debug_cmd_sync;
   import jtag_debug_pkg::*;

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] dr;
      logic [3:0]  ta;
   } cmd_t;

`ifdef JTAG_DEBUG_OVF_COUNT_EN
   localparam logic [7:0] EXP_CNT1 = 8'd1;
`else
   localparam logic [7:0] EXP_CNT1 = 8'd0;
`endif

   logic        clk;
   logic        reset_n;
   logic [37:0] sr;
   logic [1:0]  ir_in;
   logic        vs_udr, vs_uir;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] jdo;
   logic [3:0]  take_action;
   logic        ir_update;
   logic [1:0]  ir_code;
   logic [2:0]  fifo_level;
   logic        overflow, ovf_clr;
   logic [7:0]  ovf_count;

   int   total = 0;
   int   bad   = 0;
   cmd_t sbq[$];
   cmd_t vec[4];

   jtag_debug_cmd_sync #(
      .DR_WIDTH    (38),
      .IR_WIDTH    (2),
      .DEPTH       (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sr          (sr),
      .ir_in       (ir_in),
      .vs_udr      (vs_udr),
      .vs_uir      (vs_uir),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_ir      (cmd_ir),
      .jdo         (jdo),
      .take_action (take_action),
      .ir_update   (ir_update),
      .ir_code     (ir_code),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr),
      .ovf_count   (ovf_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full UDR handshake; the model accepts it only while fewer than 4 are queued.
   task automatic udr(input cmd_t c);
      ir_in  = c.ir;
      sr     = c.dr;
      vs_udr = 1'b1;
      repeat (4) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      if (sbq.size() < 4) sbq.push_back(c);
   endtask

   task automatic head_cmp(input string nm);
      cmd_t e;
      if (sbq.size() == 0) begin
         chk({nm, "_sb_empty"}, 64'(cmd_valid), 64'd0);
         return;
      end
      e = sbq.pop_front();
      chk({nm, "_valid"}, 64'(cmd_valid), 64'd1);
      chk({nm, "_ir"}, 64'(cmd_ir), 64'(e.ir));
      chk({nm, "_jdo"}, 64'(jdo), 64'(e.dr));
      chk({nm, "_ta"}, 64'(take_action), 64'(e.ta));
   endtask

   task automatic pop_chk(input string nm);
      head_cmp(nm);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
   endtask

   initial begin
      cmd_t c;
      vec[0] = '{2'd0, 38'h01_2345_6789, 4'b0001};
      vec[1] = '{2'd1, 38'h3F_FFFF_FFFF, 4'b0010};
      vec[2] = '{2'd2, 38'h00_0000_0000, 4'b0100};
      vec[3] = '{2'd3, 38'h15_A5A5_5A5A, 4'b1000};

      reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;
      ovf_clr = 1'b0; ir_in = '0; sr = '0;
      repeat (2) tick();
      chk("rst_valid", 64'(cmd_valid), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_ovfcnt", 64'(ovf_count), 64'd0);
      chk("rst_irupd", 64'(ir_update), 64'd0);
      chk("rst_ircode", 64'(ir_code), 64'd0);
      chk("rst_ta", 64'(take_action), 64'd0);
      reset_n = 1'b1;
      repeat (5) tick();

      // First command: three-edge latency, held level gives one push
      ir_in = IR_BREAK; sr = 38'h2A_DEAD_BEEF; vs_udr = 1'b1;
      tick(); chk("lat_e1", 64'(cmd_valid), 64'd0);
      tick(); chk("lat_e2", 64'(cmd_valid), 64'd0);
      tick(); chk("lat_e3", 64'(cmd_valid), 64'd1);
      chk("lat_level", 64'(fifo_level), 64'd1);
      chk("lat_jdo", 64'(jdo), 64'h2A_DEAD_BEEF);
      chk("lat_ta", 64'(take_action), 64'b0100);
      repeat (6) tick();
      chk("held_one_push", 64'(fifo_level), 64'd1);
      vs_udr = 1'b0;
      repeat (4) tick();
      sbq.push_back('{2'd2, 38'h2A_DEAD_BEEF, 4'b0100});
      pop_chk("first");
      chk("first_empty_ta", 64'(take_action), 64'd0);

      for (int i = 0; i < 4; i++) begin
         udr(vec[i]);
         pop_chk($sformatf("vec%0d", i));
      end

      // Five pushes into depth 4: fifth dropped
      for (int i = 0; i < 5; i++) begin
         c = vec[i % 4];
         c.dr = c.dr ^ 38'(i + 1);
         udr(c);
      end
      chk("ovf_level", 64'(fifo_level), 64'd4);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_cnt", 64'(ovf_count), 64'(EXP_CNT1));
      for (int i = 0; i < 4; i++) pop_chk($sformatf("drain%0d", i));
      chk("drain_valid", 64'(cmd_valid), 64'd0);
      chk("drain_ta", 64'(take_action), 64'd0);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("clr_flag", 64'(overflow), 64'd0);
      chk("clr_cnt", 64'(ovf_count), 64'd0);

      // Push into full FIFO on the same edge as a pop
      for (int i = 0; i < 4; i++) udr(vec[i]);
      c = '{2'd1, 38'h12_3456_7890, 4'b0010};
      ir_in = c.ir; sr = c.dr; vs_udr = 1'b1;
      tick(); tick();
      head_cmp("pp_head");
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      sbq.push_back(c);
      chk("pp_level", 64'(fifo_level), 64'd4);
      chk("pp_ovf", 64'(overflow), 64'd0);
      tick(); vs_udr = 1'b0; repeat (4) tick();
      for (int i = 0; i < 4; i++) pop_chk($sformatf("pp_drain%0d", i));

      // IR update pulse
      ir_in = 2'd3; vs_uir = 1'b1;
      tick(); chk("uir_e1", 64'(ir_update), 64'd0);
      tick(); chk("uir_e2", 64'(ir_update), 64'd0);
      tick(); chk("uir_e3", 64'(ir_update), 64'd1);
      chk("uir_code", 64'(ir_code), 64'd3);
      tick(); chk("uir_e4", 64'(ir_update), 64'd0);
      vs_uir = 1'b0; ir_in = 2'd0;
      repeat (4) tick();
      chk("uir_code_hold", 64'(ir_code), 64'd3);
      chk("uir_level", 64'(fifo_level), 64'd0);

      // Drop and clear in the same cycle
      for (int i = 0; i < 4; i++) udr(vec[i]);
      ir_in = 2'd0; sr = 38'h1; vs_udr = 1'b1;
      tick(); tick();
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("dc_flag", 64'(overflow), 64'd1);
      chk("dc_cnt", 64'(ovf_count), 64'(EXP_CNT1));
      chk("dc_level", 64'(fifo_level), 64'd4);
      tick(); vs_udr = 1'b0; repeat (4) tick();
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("dc_clr_flag", 64'(overflow), 64'd0);
      chk("dc_clr_cnt", 64'(ovf_count), 64'd0);
      for (int i = 0; i < 4; i++) pop_chk($sformatf("dc_drain%0d", i));

      // Ready while empty is ignored; push with ready high does not bypass
      cmd_ready = 1'b1;
      repeat (3) tick();
      chk("rdy_empty_level", 64'(fifo_level), 64'd0);
      ir_in = 2'd1; sr = 38'h0B_ADC0_FFEE; vs_udr = 1'b1;
      tick(); tick();
      chk("nb_e2_valid", 64'(cmd_valid), 64'd0);
      tick();
      chk("nb_e3_valid", 64'(cmd_valid), 64'd1);
      chk("nb_e3_jdo", 64'(jdo), 64'h0B_ADC0_FFEE);
      chk("nb_e3_ta", 64'(take_action), 64'b0010);
      tick();
      chk("nb_popped", 64'(fifo_level), 64'd0);
      cmd_ready = 1'b0; vs_udr = 1'b0;
      repeat (4) tick();

      // Asynchronous reset with queued commands and vs_udr held high
      for (int i = 0; i < 3; i++) udr(vec[i]);
      chk("rr_level3", 64'(fifo_level), 64'd3);
      vs_udr = 1'b1;
      @(posedge clk); #3 reset_n = 1'b0;
      #1;
      chk("rr_valid", 64'(cmd_valid), 64'd0);
      chk("rr_level", 64'(fifo_level), 64'd0);
      sbq.delete();
      @(posedge clk); #2 reset_n = 1'b1;
      repeat (8) tick();
      chk("rr_release_level", 64'(fifo_level), 64'd0);
      chk("rr_release_valid", 64'(cmd_valid), 64'd0);
      vs_udr = 1'b0;
      repeat (4) tick();
      udr(vec[1]);
      pop_chk("rr_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtag_debug_cmd_sync.md
JTAG_DEBUG_CMD_SYNC -- requirements
Module: jtag_debug_cmd_sync

Interface
REQ-001 The block SHALL have these parameters:
- DR_WIDTH, 38, width of the debug data register.
- IR_WIDTH, 2, width of the instruction register.
- DEPTH, 4, command FIFO depth; power of two, at least 2.
- SYNC_STAGES, 2, synchronizer flops per async input; at least 2.
REQ-002 The block SHALL have these ports:
- clk  in  1  the only clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sr  in  DR_WIDTH  shifted data register; stable while vs_udr is high.
- ir_in  in  IR_WIDTH  instruction register; stable while vs_udr or vs_uir is high.
- vs_udr  in  1  update-DR level from the TCK domain; asynchronous.
- vs_uir  in  1  update-IR level from the TCK domain; asynchronous.
- cmd_valid  out  1  FIFO head is valid.
- cmd_ready  in  1  consumer accepts the head.
- cmd_ir  out  IR_WIDTH  IR code of the head.
- jdo  out  DR_WIDTH  data of the head.
- take_action  out  2**IR_WIDTH  one-hot decode of cmd_ir, gated by cmd_valid.
- ir_update  out  1  one-cycle pulse on a synchronized IR update.
- ir_code  out  IR_WIDTH  ir_in captured at the ir_update pulse.
- fifo_level  out  $clog2(DEPTH)+1  number of queued commands.
- overflow  out  1  sticky flag: a command was dropped.
- ovf_clr  in  1  clears overflow.
- ovf_count  out  8  count of dropped commands.

Function
REQ-003 The block SHALL pass vs_udr and vs_uir each through a SYNC_STAGES-flop synchronizer followed by one edge-detect flop.
REQ-004 The block SHALL raise a push on a rising edge of synchronized vs_udr and write {ir_in, sr} into the FIFO on that same clk edge.
REQ-005 cmd_valid SHALL assert after exactly SYNC_STAGES+1 clk edges sampling vs_udr high, when the FIFO was empty (3 edges at default).
REQ-006 A vs_udr level held high for any duration SHALL produce exactly one push.
REQ-007 A rising edge of synchronized vs_uir SHALL give a one-cycle ir_update pulse with the same latency as REQ-005; ir_code SHALL hold its value until the next ir_update.
REQ-008 The FIFO SHALL be show-ahead:
- cmd_ir, jdo and take_action reflect the head whenever cmd_valid=1.
- take_action SHALL be all-zero when cmd_valid=0.
REQ-009 A pop SHALL occur when cmd_valid and cmd_ready are both high; the next entry, if any, SHALL appear on the following cycle with no bubble.
REQ-010 Pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
- Full means the pointers differ only in the MSB.
- Empty means the pointers are equal.
REQ-011 A push while full with no pop SHALL drop the command, leave the FIFO unchanged and set overflow.
REQ-012 A push while full with a simultaneous pop SHALL be accepted; fifo_level stays DEPTH.
REQ-013 A push while empty with cmd_ready high SHALL NOT bypass; the entry appears the next cycle.
REQ-014 ovf_clr SHALL clear overflow on the next edge; if a drop occurs in the same cycle, set wins.
REQ-015 cmd_ready while cmd_valid=0 SHALL be ignored.

Reset
REQ-016 reset_n low SHALL asynchronously reset the following; every other output follows from this state:
- all synchronizer and edge flops, and both pointers, to 0.
- cmd_valid=0, fifo_level=0, overflow=0, ovf_count=0.
- ir_update=0, ir_code=0, take_action=0.
REQ-017 FIFO storage SHALL NOT be reset; jdo and cmd_ir are don't-care while cmd_valid=0.
REQ-018 Reset asserted mid-operation SHALL discard all queued commands.
REQ-019 A vs_udr level still high at reset release SHALL NOT generate a push.

Configuration
REQ-020 With JTAG_DEBUG_OVF_COUNT_EN defined, ovf_count SHALL increment on each dropped command and saturate at 255.
- ovf_clr SHALL clear it; if a drop occurs in the same cycle, the increment wins and the result is 1.
REQ-021 Without JTAG_DEBUG_OVF_COUNT_EN, ovf_count SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-022 A shared package jtag_debug_pkg SHALL hold the default DR_WIDTH and IR_WIDTH constants and the IR code constants (e.g. IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3).
REQ-023 The synchronizer SHALL be one sub-module, jtag_debug_sync_edge (SYNC_STAGES flops plus rising-edge pulse), instanced twice.
- The FIFO SHALL be inline.

Verification
REQ-024 Reset, then one UDR pulse with ir_in=2 and sr=38'h2A_DEAD_BEEF, cmd_ready=0 -> cmd_valid rises 3 edges later; jdo=38'h2A_DEAD_BEEF; take_action=4'b0100; fifo_level=1.
REQ-025 Five UDR pulses with DEPTH=4 and cmd_ready=0 -> fifo_level=4; overflow=1; ovf_count=1 (macro on) or 0 (macro off); then four pops return the first four commands in order.
REQ-026 Full FIFO, with the push edge and a pop in the same cycle -> no overflow; fifo_level stays 4; the fifth command becomes the tail.
REQ-027 UIR pulse with ir_in=3 -> one ir_update pulse 3 edges later; ir_code=3; FIFO unchanged.
REQ-028 Three queued commands, then reset_n pulsed low mid-cycle -> cmd_valid=0 immediately; fifo_level=0; no push on release with vs_udr held high.
REQ-029 Drop and ovf_clr in the same cycle -> overflow stays 1; ovf_count=1.
